// File: rtl/sram_req_responder_if.sv
// Requester-side bundle of the rd_0/wr_0 SRAM request interface.
interface sram_req_responder_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int WORD_WIDTH = 72
);
    logic                  rd_0_req;
    logic [ADDR_WIDTH-1:0] rd_0_addr;
    logic                  rd_0_ack;
    logic                  rd_0_vld;
    logic [WORD_WIDTH-1:0] rd_0_data;
    logic                  wr_0_req;
    logic [ADDR_WIDTH-1:0] wr_0_addr;
    logic [WORD_WIDTH-1:0] wr_0_data;
    logic                  wr_0_ack;

    modport master (
        output rd_0_req, rd_0_addr, wr_0_req, wr_0_addr, wr_0_data,
        input  rd_0_ack, rd_0_vld, rd_0_data, wr_0_ack
    );

    modport slave (
        input  rd_0_req, rd_0_addr, wr_0_req, wr_0_addr, wr_0_data,
        output rd_0_ack, rd_0_vld, rd_0_data, wr_0_ack
    );
endinterface

// File: rtl/sram_req_responder.sv
// Arbitrates rd_0/wr_0 requests onto one pipelined SRAM port, returns read data,
// and zero-fills the whole table after reset or on table_flush.
module sram_req_responder #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = 8,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_RD_LATENCY = 2,
    parameter bit CLEAR_ON_RESET  = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    sram_req_responder_if.slave                  bus,
    input  logic                                 table_flush,
    output logic                                 init_done,
    output logic                                 sram_en,
    output logic                                 sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0]           sram_addr,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0]     sram_wr_data,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0]     sram_rd_data
);
    localparam int A = SRAM_ADDR_WIDTH;
    localparam int W = DATA_WIDTH + CTRL_WIDTH;
    localparam int L = SRAM_RD_LATENCY;
    localparam logic [A-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {CLEAR, SERVE, DRAIN} state_t;

    state_t         state, state_nx;
    logic [A-1:0]   clear_addr, clear_addr_nx;
    logic           last_grant_wr;
    logic [L:0]     vld_pipe;

    logic           rd_elig, wr_elig, grant_rd, grant_wr;
    logic           cmd_en, cmd_we;
    logic [A-1:0]   cmd_addr;
    logic [W-1:0]   cmd_data;

    // A request seen during its own ack cycle is the one just served.
    assign rd_elig = bus.rd_0_req && !bus.rd_0_ack;
    assign wr_elig = bus.wr_0_req && !bus.wr_0_ack;

    always_comb begin
        state_nx      = state;
        clear_addr_nx = clear_addr;
        grant_rd      = 1'b0;
        grant_wr      = 1'b0;
        cmd_en        = 1'b0;
        cmd_we        = 1'b0;
        cmd_addr      = '0;
        cmd_data      = '0;
        case (state)
            CLEAR: begin
                if (table_flush) begin
                    clear_addr_nx = '0;
                end else begin
                    cmd_en        = 1'b1;
                    cmd_we        = 1'b1;
                    cmd_addr      = clear_addr;
                    clear_addr_nx = clear_addr + 1'b1;
                    if (clear_addr == ADDR_LAST)
                        state_nx = SERVE;
                end
            end
            SERVE: begin
                if (table_flush) begin
                    state_nx = DRAIN;
                end else if (rd_elig && (!wr_elig || last_grant_wr)) begin
                    grant_rd = 1'b1;
                    cmd_en   = 1'b1;
                    cmd_addr = bus.rd_0_addr;
                end else if (wr_elig) begin
                    grant_wr = 1'b1;
                    cmd_en   = 1'b1;
                    cmd_we   = 1'b1;
                    cmd_addr = bus.wr_0_addr;
                    cmd_data = bus.wr_0_data;
                end
            end
            DRAIN: begin
                // Reads already issued must be delivered before the table is wiped.
                if (vld_pipe == '0) begin
                    state_nx      = CLEAR;
                    clear_addr_nx = '0;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR_ON_RESET ? CLEAR : SERVE;
            clear_addr <= '0;
        end else begin
            state      <= state_nx;
            clear_addr <= clear_addr_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_wr <= 1'b1;
            vld_pipe      <= '0;
            init_done     <= 1'b0;
            sram_en       <= 1'b0;
            sram_we       <= 1'b0;
            sram_addr     <= '0;
            sram_wr_data  <= '0;
            bus.rd_0_ack  <= 1'b0;
            bus.wr_0_ack  <= 1'b0;
            bus.rd_0_vld  <= 1'b0;
            bus.rd_0_data <= '0;
        end else begin
            if (grant_rd)
                last_grant_wr <= 1'b0;
            else if (grant_wr)
                last_grant_wr <= 1'b1;
            vld_pipe      <= {vld_pipe[L-1:0], grant_rd};
            init_done     <= (state == SERVE) && (state_nx == SERVE);
            sram_en       <= cmd_en;
            sram_we       <= cmd_we;
            sram_addr     <= cmd_addr;
            sram_wr_data  <= cmd_data;
            bus.rd_0_ack  <= grant_rd;
            bus.wr_0_ack  <= grant_wr;
            bus.rd_0_vld  <= vld_pipe[L];
            if (vld_pipe[L])
                bus.rd_0_data <= sram_rd_data;
        end
    end
endmodule

// File: tb/tb_sram_req_responder.sv
// Randomized bench for sram_req_responder with a behavioural SRAM and a scoreboard model.
module tb_sram_req_responder;
    localparam int A = 4;
    localparam int W = 72;
    localparam int L = 2;
    localparam int N = 2 ** A;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         table_flush;
    logic         init_done, sram_en, sram_we;
    logic [A-1:0] sram_addr;
    logic [W-1:0] sram_wr_data, sram_rd_data;

    sram_req_responder_if #(.ADDR_WIDTH(A), .WORD_WIDTH(W)) bus ();

    sram_req_responder #(
        .DATA_WIDTH(64), .CTRL_WIDTH(8), .SRAM_ADDR_WIDTH(A),
        .SRAM_RD_LATENCY(L), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .table_flush(table_flush),
        .init_done(init_done), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous SRAM: read data visible L cycles after the command cycle.
    logic [W-1:0] sram_mem [N];
    logic [W-1:0] rd_pipe  [L];
    always @(posedge clk) begin
        if (sram_en && sram_we) sram_mem[sram_addr] <= sram_wr_data;
        if (sram_en && !sram_we) rd_pipe[0] <= sram_mem[sram_addr];
        for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign sram_rd_data = rd_pipe[L-1];

    typedef struct { logic [W-1:0] d; int c; } exp_t;
    exp_t         exp_q[$];
    logic [W-1:0] ref_mem [N];
    int           n_tests = 0, n_fail = 0, cyc = 0;
    bit           m_rd_ack, m_wr_ack, m_last_wr = 1'b1, m_serve;
    bit           got_vld, pop_none;
    logic [W-1:0] pop_data;
    int           pop_cyc;

    task automatic model_reset();
        exp_q.delete();
        m_rd_ack = 1'b0; m_wr_ack = 1'b0; m_last_wr = 1'b1; m_serve = 1'b0;
    endtask

    // Advance one clock; the model decides grants from the arbitration rules and
    // records the data each accepted read must return.
    task automatic cycle();
        bit er, ew, gr, gw;
        er = bus.rd_0_req && !m_rd_ack;
        ew = bus.wr_0_req && !m_wr_ack;
        gr = reset && m_serve && !table_flush && er && (!ew || m_last_wr);
        gw = reset && m_serve && !table_flush && ew && !gr;
        @(posedge clk);
        #1;
        cyc++;
        m_rd_ack = gr; m_wr_ack = gw;
        if (gr) m_last_wr = 1'b0;
        if (gw) m_last_wr = 1'b1;
        if (gw) ref_mem[bus.wr_0_addr] = bus.wr_0_data;
        if (gr) exp_q.push_back('{d: ref_mem[bus.rd_0_addr], c: cyc});
        got_vld  = bus.rd_0_vld;
        pop_none = 1'b0;
        if (got_vld) begin
            if (exp_q.size() == 0) pop_none = 1'b1;
            else begin
                pop_data = exp_q[0].d; pop_cyc = exp_q[0].c;
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_tests++;
            if ({bus.rd_0_ack, bus.rd_0_vld, bus.rd_0_data, bus.wr_0_ack, init_done,
                 sram_en, sram_we, sram_addr, sram_wr_data} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: en=%b we=%b addr=%h init=%b acks=%b%b vld=%b, expected all 0",
                         sram_en, sram_we, sram_addr, init_done, bus.rd_0_ack, bus.wr_0_ack, bus.rd_0_vld);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_clear();
        bus.rd_0_req = 1'b1; bus.rd_0_addr = '0;
        for (int i = 0; i < N; i++) begin
            cycle();
            if (i == 7) bus.rd_0_req = 1'b0;
            n_tests++;
            if ({bus.rd_0_ack, bus.wr_0_ack, bus.rd_0_vld, init_done, sram_en, sram_we, sram_addr, sram_wr_data}
                !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'(i), 72'h0}) begin
                n_fail++;
                $display("FAIL clear_write[%0d]: en=%b we=%b addr=%0d data=%h acks=%b%b vld=%b init=%b, expected write 0 to %0d",
                         i, sram_en, sram_we, sram_addr, sram_wr_data, bus.rd_0_ack, bus.wr_0_ack,
                         bus.rd_0_vld, init_done, i);
            end
        end
        m_serve = 1'b1;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
        cycle();
        n_tests++;
        if ({init_done, sram_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL clear_done: init_done=%b sram_en=%b, expected 1 0", init_done, sram_en);
        end
    endtask

    task automatic test_first_tie();
        bus.rd_0_req = 1'b1; bus.rd_0_addr = 4'd9;
        bus.wr_0_req = 1'b1; bus.wr_0_addr = 4'd9; bus.wr_0_data = 72'($urandom);
        cycle();
        bus.rd_0_req = 1'b0;
        n_tests++;
        if ({bus.rd_0_ack, bus.wr_0_ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL first_tie: acks rd/wr=%b%b, expected 10", bus.rd_0_ack, bus.wr_0_ack);
        end
        cycle();
        bus.wr_0_req = 1'b0;
        n_tests++;
        if ({bus.rd_0_ack, bus.wr_0_ack} !== 2'b01) begin
            n_fail++;
            $display("FAIL first_tie_wr: acks rd/wr=%b%b, expected 01", bus.rd_0_ack, bus.wr_0_ack);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (got_vld) begin
                n_tests++;
                if (pop_none || bus.rd_0_data !== 72'h0 || cyc - pop_cyc != 3) begin
                    n_fail++;
                    $display("FAIL first_tie_rdata: data=%h lat=%0d, expected 0 lat 3", bus.rd_0_data, cyc - pop_cyc);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int n;
        bus.wr_0_req = 1'b1; bus.wr_0_addr = 4'd5; bus.wr_0_data = 72'hAB;
        cycle();
        bus.wr_0_req = 1'b0;
        n_tests++;
        if ({bus.wr_0_ack, sram_en, sram_we, sram_addr, sram_wr_data} !== {1'b1, 1'b1, 1'b1, 4'd5, 72'hAB}) begin
            n_fail++;
            $display("FAIL wr_issue: ack=%b en=%b we=%b addr=%0d data=%h, expected 1 1 1 5 ab",
                     bus.wr_0_ack, sram_en, sram_we, sram_addr, sram_wr_data);
        end
        cycle();
        n_tests++;
        if (bus.wr_0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack_pulse: ack=%b, expected 0", bus.wr_0_ack);
        end
        bus.rd_0_req = 1'b1; bus.rd_0_addr = 4'd5;
        cycle();
        bus.rd_0_req = 1'b0;
        n_tests++;
        if ({bus.rd_0_ack, sram_en, sram_we, sram_addr} !== {1'b1, 1'b1, 1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL rd_issue: ack=%b en=%b we=%b addr=%0d, expected 1 1 0 5",
                     bus.rd_0_ack, sram_en, sram_we, sram_addr);
        end
        n = 0;
        do begin cycle(); n++; end while (!got_vld && n < 8);
        n_tests++;
        if (!got_vld || n != 3 || bus.rd_0_data !== 72'hAB) begin
            n_fail++;
            $display("FAIL rd_return: vld=%b after %0d cycles data=%h, expected vld after 3 data ab",
                     got_vld, n, bus.rd_0_data);
        end
    endtask

    task automatic test_alternate();
        bus.rd_0_req = 1'b1; bus.rd_0_addr = 4'($urandom);
        bus.wr_0_req = 1'b1; bus.wr_0_addr = 4'($urandom); bus.wr_0_data = 72'({$urandom, $urandom, $urandom});
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_tests++;
            if ({bus.rd_0_ack, bus.wr_0_ack} !== {m_rd_ack, m_wr_ack} || !(m_rd_ack ^ m_wr_ack)) begin
                n_fail++;
                $display("FAIL alt_grant[%0d]: acks rd/wr=%b%b, expected %b%b",
                         i, bus.rd_0_ack, bus.wr_0_ack, m_rd_ack, m_wr_ack);
            end
            if (got_vld) begin
                n_tests++;
                if (pop_none || bus.rd_0_data !== pop_data || cyc - pop_cyc != 3) begin
                    n_fail++;
                    $display("FAIL alt_rdata: data=%h lat=%0d, expected %h lat 3", bus.rd_0_data, cyc - pop_cyc, pop_data);
                end
            end
            if (bus.rd_0_ack) bus.rd_0_addr = 4'($urandom);
            if (bus.wr_0_ack) begin
                bus.wr_0_addr = 4'($urandom); bus.wr_0_data = 72'({$urandom, $urandom, $urandom});
            end
        end
        bus.rd_0_req = 1'b0; bus.wr_0_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (got_vld) begin
                n_tests++;
                if (pop_none || bus.rd_0_data !== pop_data || cyc - pop_cyc != 3) begin
                    n_fail++;
                    $display("FAIL alt_rdata: data=%h lat=%0d, expected %h lat 3", bus.rd_0_data, cyc - pop_cyc, pop_data);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL alt_missing_vld: %0d reads outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d1, d2;
        int nv;
        d1 = 72'({$urandom, $urandom, $urandom}); d2 = 72'({$urandom, $urandom, $urandom});
        bus.wr_0_req = 1'b1; bus.wr_0_addr = 4'd1; bus.wr_0_data = d1;
        cycle();
        bus.wr_0_addr = 4'd2; bus.wr_0_data = d2;
        cycle(); cycle();
        bus.wr_0_req = 1'b0;
        bus.rd_0_req = 1'b1; bus.rd_0_addr = 4'd1;
        cycle();
        bus.rd_0_addr = 4'd2;
        n_tests++;
        if (bus.rd_0_ack !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ack1: ack=%b, expected 1", bus.rd_0_ack);
        end
        cycle();
        n_tests++;
        if (bus.rd_0_ack !== 1'b0) begin
            n_fail++; $display("FAIL b2b_stale: ack=%b, expected 0", bus.rd_0_ack);
        end
        cycle();
        bus.rd_0_req = 1'b0;
        n_tests++;
        if (bus.rd_0_ack !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ack2: ack=%b, expected 1", bus.rd_0_ack);
        end
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (got_vld) begin
                n_tests++;
                if (bus.rd_0_data !== (nv == 0 ? d1 : d2) || cyc - pop_cyc != 3) begin
                    n_fail++;
                    $display("FAIL b2b_rdata[%0d]: data=%h lat=%0d, expected %h lat 3",
                             nv, bus.rd_0_data, cyc - pop_cyc, (nv == 0 ? d1 : d2));
                end
                nv++;
            end
        end
        n_tests++;
        if (nv != 2) begin
            n_fail++; $display("FAIL b2b_count: %0d returns, expected 2", nv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if (bus.rd_0_ack || !bus.rd_0_req) begin
                bus.rd_0_req = ($urandom % 2) == 1; bus.rd_0_addr = 4'($urandom);
            end
            if (bus.wr_0_ack || !bus.wr_0_req) begin
                bus.wr_0_req = ($urandom % 3) == 0; bus.wr_0_addr = 4'($urandom);
                bus.wr_0_data = 72'({$urandom, $urandom, $urandom});
            end
            if (i >= 290) begin bus.rd_0_req = 1'b0; bus.wr_0_req = 1'b0; end
            cycle();
            n_tests++;
            if ({bus.rd_0_ack, bus.wr_0_ack} !== {m_rd_ack, m_wr_ack}) begin
                n_fail++;
                $display("FAIL rand_grant@%0d: acks rd/wr=%b%b, expected %b%b",
                         cyc, bus.rd_0_ack, bus.wr_0_ack, m_rd_ack, m_wr_ack);
            end
            if (got_vld) begin
                n_tests++;
                if (pop_none || bus.rd_0_data !== pop_data || cyc - pop_cyc != 3) begin
                    n_fail++;
                    $display("FAIL rand_rdata@%0d: data=%h lat=%0d unexpected=%b, expected %h lat 3",
                             cyc, bus.rd_0_data, cyc - pop_cyc, pop_none, pop_data);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_missing_vld: %0d reads outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_flush_drain();
        logic [W-1:0] x;
        bit seen;
        int nclr, n;
        x = 72'({$urandom, $urandom, $urandom}) | 72'h1;
        bus.wr_0_req = 1'b1; bus.wr_0_addr = 4'd5; bus.wr_0_data = x;
        cycle();
        bus.wr_0_req = 1'b0;
        bus.rd_0_req = 1'b1; bus.rd_0_addr = 4'd5;
        cycle();
        bus.rd_0_req = 1'b0;
        table_flush = 1'b1;
        bus.wr_0_req = 1'b1; bus.wr_0_addr = 4'd3; bus.wr_0_data = '1;
        cycle();
        table_flush = 1'b0; bus.wr_0_req = 1'b0; m_serve = 1'b0;
        n_tests++;
        if ({bus.wr_0_ack, sram_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_blocks_req: wr_ack=%b sram_en=%b, expected 0 0", bus.wr_0_ack, sram_en);
        end
        seen = 1'b0; nclr = 0;
        for (int i = 0; i < 40 && nclr < N; i++) begin
            cycle();
            if (got_vld) begin
                seen = 1'b1;
                n_tests++;
                if (bus.rd_0_data !== x || cyc - pop_cyc != 3) begin
                    n_fail++;
                    $display("FAIL drain_rdata: data=%h lat=%0d, expected %h lat 3", bus.rd_0_data, cyc - pop_cyc, x);
                end
            end
            if (sram_en) begin
                n_tests++;
                if (!seen || {sram_we, sram_addr, sram_wr_data} !== {1'b1, 4'(nclr), 72'h0}) begin
                    n_fail++;
                    $display("FAIL drain_clear[%0d]: vld_seen=%b we=%b addr=%0d data=%h, expected after vld: write 0 to %0d",
                             nclr, seen, sram_we, sram_addr, sram_wr_data, nclr);
                end
                nclr++;
            end
        end
        n_tests++;
        if (!seen || nclr != N) begin
            n_fail++; $display("FAIL drain_bound: vld_seen=%b clears=%0d, expected 1 and 16", seen, nclr);
        end
        m_serve = 1'b1;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
        bus.rd_0_req = 1'b1; bus.rd_0_addr = 4'd5;
        cycle();
        bus.rd_0_req = 1'b0;
        n_tests++;
        if ({init_done, bus.rd_0_ack} !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_serve: init_done=%b rd_ack=%b, expected 1 1", init_done, bus.rd_0_ack);
        end
        n = 0;
        do begin cycle(); n++; end while (!got_vld && n < 8);
        n_tests++;
        if (!got_vld || n != 3 || bus.rd_0_data !== 72'h0) begin
            n_fail++;
            $display("FAIL flush_cleared: vld=%b after %0d data=%h, expected vld after 3 data 0", got_vld, n, bus.rd_0_data);
        end
    endtask

    task automatic test_reset_drain();
        bus.rd_0_req = 1'b1; bus.rd_0_addr = 4'd7;
        cycle();
        bus.rd_0_req = 1'b0;
        table_flush = 1'b1;
        cycle();
        table_flush = 1'b0; m_serve = 1'b0;
        #3 reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.rd_0_ack, bus.rd_0_vld, bus.rd_0_data, bus.wr_0_ack, init_done,
             sram_en, sram_we, sram_addr, sram_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: en=%b vld=%b data=%h init=%b, expected all 0",
                     sram_en, bus.rd_0_vld, bus.rd_0_data, init_done);
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if ({bus.rd_0_vld, sram_en} !== 2'b00) begin
                n_fail++; $display("FAIL reset_hold: vld=%b en=%b, expected 0 0", bus.rd_0_vld, sram_en);
            end
        end
        reset = 1'b1;
        test_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected bench to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_0_req = 1'b0; bus.rd_0_addr = '0;
        bus.wr_0_req = 1'b0; bus.wr_0_addr = '0; bus.wr_0_data = '0;
        table_flush = 1'b0;
        test_reset();
        test_clear();
        test_first_tie();
        test_write_read();
        test_alternate();
        test_back_to_back();
        test_random();
        test_flush_drain();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
